// File: rtl/access_ctrl_pkg.sv
// Shared encodings for the door-access controller: FSM states, keypad codes
// and LCD message selectors.
package access_ctrl_pkg;

    // One-hot state encoding; any other pattern is treated as illegal and
    // recovers to S_IDLE on the next cycle.
    typedef enum logic [5:0] {
        S_IDLE      = 6'b000001,
        S_PROFILE   = 6'b000010,
        S_PIN       = 6'b000100,
        S_OPEN      = 6'b001000,
        S_DOOR_OPEN = 6'b010000,
        S_ALARM     = 6'b100000
    } state_t;

    // Keypad scanner codes (0-9 are digits, A-D letters).
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // LCD message mux selectors.
    localparam logic [2:0] LCD_BLANK    = 3'd0;
    localparam logic [2:0] LCD_PROFILE  = 3'd1;
    localparam logic [2:0] LCD_PIN      = 3'd2;
    localparam logic [2:0] LCD_OPEN     = 3'd3;
    localparam logic [2:0] LCD_ERROR    = 3'd4;
    localparam logic [2:0] LCD_INTRUDER = 3'd5;
    localparam logic [2:0] LCD_AJAR     = 3'd6;

    // Ajar buzzer toggles every 2^AJAR_TOG_BITS cycles.
    localparam int unsigned AJAR_TOG_BITS = 24;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/access_ctrl_fsm_pin_entry_buf.sv
// PIN entry buffer: shifts keypad digits in (first digit ends up in the LSBs),
// tracks a saturating digit count whose top value marks overflow, and compares
// the buffer against the PIN_TABLE entry of the selected profile.
module pin_entry_buf
    import access_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PROFILES = 4,
    parameter int unsigned PIN_DIGITS   = 4,
    parameter logic [NUM_PROFILES*PIN_DIGITS*4-1:0] PIN_TABLE = 64'h6789_0000_4321_3964
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift,
    input  logic [3:0] digit,
    input  logic [3:0] sel_id,
    output logic       match
);

    localparam int unsigned BW = PIN_DIGITS * 4;
    localparam int unsigned CW = $clog2(PIN_DIGITS + 2);

    logic [BW-1:0] pin_buf;
    logic [CW-1:0] count;
    logic          overflow;
    logic [BW-1:0] expected;
    int unsigned   slot;

    assign overflow = (count == CW'(PIN_DIGITS + 1));

    // Digit shift register and saturating count; clear has priority over shift.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pin_buf <= '0;
            count   <= '0;
        end else if (shift) begin
            pin_buf <= (pin_buf >> 4) | (BW'(digit) << (BW - 4));
            if (!overflow)
                count <= count + 1'b1;
        end
    end

    // Select the stored PIN (out-of-range ids fall back to slot 0) and compare.
    always_comb begin
        slot     = (32'(sel_id) < NUM_PROFILES) ? 32'(sel_id) : 0;
        expected = PIN_TABLE[slot*BW +: BW];
        match    = (count == CW'(PIN_DIGITS)) && (pin_buf == expected);
    end

endmodule

// File: rtl/access_ctrl_fsm.sv
// Door-access controller: presence wake-up, profile + PIN entry, latch servo
// control, reed-switch supervision and alarm/lockout on repeated failures.
// Optional feature macro: DOOR_AJAR_ALARM_EN (door-ajar buzzer in DOOR_OPEN).
module access_ctrl_fsm
    import access_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PROFILES = 4,
    parameter int unsigned PIN_DIGITS   = 4,
    parameter logic [NUM_PROFILES*PIN_DIGITS*4-1:0] PIN_TABLE = 64'h6789_0000_4321_3964,
    parameter int unsigned MAX_TRIES    = 3,
    parameter int unsigned TIMEOUT_CYC  = 250_000_000,
    parameter int unsigned OPEN_CYC     = 500_000_000,
    parameter int unsigned ALARM_CYC    = 1_500_000_000,
    parameter int unsigned AJAR_CYC     = 1_500_000_000,
    localparam int unsigned FW = $clog2(MAX_TRIES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          presence,
    input  logic          key_valid,
    input  logic [3:0]    key_code,
    input  logic          reed_closed,
    output logic          servo_open,
    output logic          buzz,
    output logic [2:0]    lcd_msg,
    output logic [3:0]    profile_id,
    output logic [FW-1:0] fail_cnt
);

    state_t        state, state_n;
    logic [31:0]   timer, timer_n;
    logic [3:0]    cand_id, cand_id_n;
    logic          cand_valid, cand_valid_n;
    logic          err, err_n;
    logic [FW-1:0] fail_n;
    logic [3:0]    profile_n;
    logic          servo_n, buzz_n;
    logic [2:0]    lcd_n;
    logic          pin_clear, pin_shift, pin_match;
    logic          ajar_n;
    logic          is_star, is_hash, is_num;

`ifdef DOOR_AJAR_ALARM_EN
    logic                     ajar;
    logic [AJAR_TOG_BITS-1:0] ajar_cnt, ajar_cnt_n;
`endif

    assign is_num  = is_digit(key_code);
    assign is_star = (key_code == KEY_STAR);
    assign is_hash = (key_code == KEY_HASH);

    pin_entry_buf #(
        .NUM_PROFILES (NUM_PROFILES),
        .PIN_DIGITS   (PIN_DIGITS),
        .PIN_TABLE    (PIN_TABLE)
    ) u_pin_buf (
        .clk    (clk),
        .reset  (reset),
        .clear  (pin_clear),
        .shift  (pin_shift),
        .digit  (key_code),
        .sel_id (profile_id),
        .match  (pin_match)
    );

    // Next-state, timer reload, entry buffers and next registered outputs.
    always_comb begin
        state_n      = state;
        timer_n      = (timer != '0) ? timer - 32'd1 : timer;
        cand_id_n    = cand_id;
        cand_valid_n = cand_valid;
        err_n        = err;
        fail_n       = fail_cnt;
        profile_n    = profile_id;
        pin_clear    = 1'b0;
        pin_shift    = 1'b0;
        ajar_n       = 1'b0;
`ifdef DOOR_AJAR_ALARM_EN
        ajar_cnt_n   = '0;
`endif

        case (state)
            S_IDLE: begin
                if (!reed_closed)
                    state_n = S_ALARM;
                else if (presence)
                    state_n = S_PROFILE;
            end
            S_PROFILE: begin
                if (!reed_closed) begin
                    state_n = S_ALARM;
                end else if (key_valid) begin
                    timer_n = TIMEOUT_CYC - 1;
                    if (is_num) begin
                        cand_id_n    = key_code;
                        cand_valid_n = 1'b1;
                        err_n        = 1'b0;
                    end else if (is_star) begin
                        if (cand_valid && (32'(cand_id) < NUM_PROFILES)) begin
                            state_n   = S_PIN;
                            profile_n = cand_id;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end else if (timer == '0) begin
                    state_n = S_IDLE;
                end
            end
            S_PIN: begin
                if (!reed_closed) begin
                    state_n = S_ALARM;
                end else if (key_valid) begin
                    timer_n = TIMEOUT_CYC - 1;
                    if (is_num) begin
                        pin_shift = 1'b1;
                    end else if (is_star) begin
                        pin_clear = 1'b1;
                    end else if (is_hash) begin
                        if (pin_match) begin
                            state_n = S_OPEN;
                            fail_n  = '0;
                        end else begin
                            fail_n  = fail_cnt + 1'b1;
                            state_n = (fail_cnt == FW'(MAX_TRIES - 1)) ? S_ALARM : S_PROFILE;
                        end
                    end
                end else if (timer == '0) begin
                    state_n = S_IDLE;
                end
            end
            S_OPEN: begin
                if (!reed_closed)
                    state_n = S_DOOR_OPEN;
                else if (timer == '0)
                    state_n = S_IDLE;
            end
            S_DOOR_OPEN: begin
                if (reed_closed)
                    state_n = S_IDLE;
`ifdef DOOR_AJAR_ALARM_EN
                else
                    ajar_n = ajar || (timer == '0);
`endif
            end
            S_ALARM: begin
                if (timer == '0) begin
                    state_n = S_IDLE;
                    fail_n  = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Shared down-counter reloads with the limit of whichever state is entered.
        if (state_n != state) begin
            case (state_n)
                S_PROFILE, S_PIN: timer_n = TIMEOUT_CYC - 1;
                S_OPEN:           timer_n = OPEN_CYC - 1;
                S_DOOR_OPEN:      timer_n = AJAR_CYC - 1;
                S_ALARM:          timer_n = ALARM_CYC - 1;
                default:          timer_n = '0;
            endcase
        end

        // Candidate id and PIN buffer live only while their state is held.
        if (state_n != S_PROFILE) begin
            cand_id_n    = '0;
            cand_valid_n = 1'b0;
            err_n        = 1'b0;
        end
        if ((state_n != S_PIN) || (state != S_PIN))
            pin_clear = 1'b1;

        servo_n = (state_n == S_OPEN) || (state_n == S_DOOR_OPEN);
        buzz_n  = (state_n == S_ALARM);
`ifdef DOOR_AJAR_ALARM_EN
        if (ajar_n) begin
            if (ajar) begin
                ajar_cnt_n = ajar_cnt + 1'b1;
                buzz_n     = (&ajar_cnt) ? ~buzz : buzz;
            end else begin
                buzz_n = 1'b1;
            end
        end
`endif

        case (state_n)
            S_PROFILE:   lcd_n = err_n ? LCD_ERROR : LCD_PROFILE;
            S_PIN:       lcd_n = LCD_PIN;
            S_OPEN:      lcd_n = LCD_OPEN;
            S_DOOR_OPEN: lcd_n = ajar_n ? LCD_AJAR : LCD_OPEN;
            S_ALARM:     lcd_n = LCD_INTRUDER;
            default:     lcd_n = LCD_BLANK;
        endcase
    end

    // State, timer, entry bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            cand_id    <= '0;
            cand_valid <= 1'b0;
            err        <= 1'b0;
            fail_cnt   <= '0;
            profile_id <= '0;
            servo_open <= 1'b0;
            buzz       <= 1'b0;
            lcd_msg    <= LCD_BLANK;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            cand_id    <= cand_id_n;
            cand_valid <= cand_valid_n;
            err        <= err_n;
            fail_cnt   <= fail_n;
            profile_id <= profile_n;
            servo_open <= servo_n;
            buzz       <= buzz_n;
            lcd_msg    <= lcd_n;
        end
    end

`ifdef DOOR_AJAR_ALARM_EN
    // Ajar flag and buzzer toggle prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            ajar     <= 1'b0;
            ajar_cnt <= '0;
        end else begin
            ajar     <= ajar_n;
            ajar_cnt <= ajar_cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_access_ctrl_fsm.sv
// Directed self-checking bench for access_ctrl_fsm with shortened timers.
module tb_access_ctrl_fsm;
    import access_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       presence;
    logic       key_valid;
    logic [3:0] key_code;
    logic       reed_closed;
    logic       servo_open;
    logic       buzz;
    logic [2:0] lcd_msg;
    logic [3:0] profile_id;
    logic [1:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    access_ctrl_fsm #(
        .NUM_PROFILES (4),
        .PIN_DIGITS   (4),
        .MAX_TRIES    (3),
        .TIMEOUT_CYC  (100),
        .OPEN_CYC     (50),
        .ALARM_CYC    (40),
        .AJAR_CYC     (60)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .presence    (presence),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .reed_closed (reed_closed),
        .servo_open  (servo_open),
        .buzz        (buzz),
        .lcd_msg     (lcd_msg),
        .profile_id  (profile_id),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; presence = 1'b0; key_valid = 1'b0; key_code = 4'h0; reed_closed = 1'b1;
        tick(2);
        chk("rst_servo", 32'(servo_open), 0);
        chk("rst_buzz", 32'(buzz), 0);
        chk("rst_lcd", 32'(lcd_msg), 0);
        chk("rst_pid", 32'(profile_id), 0);
        chk("rst_fail", 32'(fail_cnt), 0);
        reset = 1'b0;

        // Good entry for profile 0, door cycle.
        presence = 1'b1; tick(1);
        chk("wake_lcd", 32'(lcd_msg), 1);
        press(4'd0); press(KEY_STAR);
        chk("pin_lcd", 32'(lcd_msg), 2);
        press(4'd4); press(4'd6); press(4'd9); press(4'd3); press(KEY_HASH);
        chk("open_servo", 32'(servo_open), 1);
        chk("open_lcd", 32'(lcd_msg), 3);
        chk("open_pid", 32'(profile_id), 0);
        presence = 1'b0; reed_closed = 1'b0; tick(1);
        chk("dooropen_servo", 32'(servo_open), 1);
        reed_closed = 1'b1; tick(1);
        chk("close_servo", 32'(servo_open), 0);
        chk("close_lcd", 32'(lcd_msg), 0);

        // Three wrong PINs -> lockout alarm.
        presence = 1'b1; tick(1);
        press(4'd0); press(KEY_STAR);
        press(4'd1); press(4'd1); press(4'd1); press(4'd1); press(KEY_HASH);
        chk("fail1_cnt", 32'(fail_cnt), 1);
        chk("fail1_lcd", 32'(lcd_msg), 1);
        press(4'd0); press(KEY_STAR);
        press(4'd1); press(4'd1); press(4'd1); press(4'd1); press(KEY_HASH);
        chk("fail2_cnt", 32'(fail_cnt), 2);
        press(4'd0); press(KEY_STAR);
        press(4'd1); press(4'd1); press(4'd1); press(4'd1); press(KEY_HASH);
        presence = 1'b0;
        chk("alarm_buzz", 32'(buzz), 1);
        chk("alarm_lcd", 32'(lcd_msg), 5);
        chk("alarm_fail", 32'(fail_cnt), 3);
        press(KEY_HASH);
        tick(37);
        chk("alarm_c39_buzz", 32'(buzz), 1);
        tick(1);
        chk("alarm_c40_buzz", 32'(buzz), 1);
        chk("alarm_c40_lcd", 32'(lcd_msg), 5);
        tick(1);
        chk("alarm_end_buzz", 32'(buzz), 0);
        chk("alarm_end_fail", 32'(fail_cnt), 0);

        // Short and long PINs rejected; '*' clears partial PIN; OPEN relock timeout.
        presence = 1'b1; tick(1);
        press(4'd0); press(KEY_STAR);
        press(4'd4); press(4'd6); press(4'd9); press(KEY_HASH);
        chk("short_fail", 32'(fail_cnt), 1);
        press(4'd0); press(KEY_STAR);
        press(4'd4); press(4'd6); press(4'd9); press(4'd3); press(4'd3); press(KEY_HASH);
        chk("long_fail", 32'(fail_cnt), 2);
        chk("long_lcd", 32'(lcd_msg), 1);
        press(4'd0); press(KEY_STAR); press(4'd1); press(4'd2); press(KEY_STAR);
        press(4'd4); press(4'd6); press(4'd9); press(4'd3); press(KEY_HASH);
        presence = 1'b0;
        chk("clr_open_servo", 32'(servo_open), 1);
        chk("clr_open_fail", 32'(fail_cnt), 0);
        tick(48);
        chk("open_c49_servo", 32'(servo_open), 1);
        tick(1);
        chk("open_c50_servo", 32'(servo_open), 1);
        tick(1);
        chk("relock_servo", 32'(servo_open), 0);
        chk("relock_lcd", 32'(lcd_msg), 0);

        // Profile id errors, then profile 3 (PIN 9876), door held open.
        presence = 1'b1; tick(1);
        press(KEY_STAR);
        chk("star_nodigit_lcd", 32'(lcd_msg), 4);
        press(4'd9);
        chk("digit_clears_err", 32'(lcd_msg), 1);
        press(KEY_STAR);
        chk("bad_id_lcd", 32'(lcd_msg), 4);
        chk("bad_id_fail", 32'(fail_cnt), 0);
        press(4'd3); press(KEY_STAR);
        chk("id3_lcd", 32'(lcd_msg), 2);
        press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(KEY_HASH);
        chk("id3_pid", 32'(profile_id), 3);
        chk("id3_servo", 32'(servo_open), 1);
        presence = 1'b0; reed_closed = 1'b0; tick(1);
        tick(58);
        chk("ajar_c59_lcd", 32'(lcd_msg), 3);
        tick(2);
`ifdef DOOR_AJAR_ALARM_EN
        chk("ajar_lcd", 32'(lcd_msg), 6);
        chk("ajar_buzz", 32'(buzz), 1);
`else
        chk("noajar_lcd", 32'(lcd_msg), 3);
        chk("noajar_buzz", 32'(buzz), 0);
`endif
        reed_closed = 1'b1; tick(1);
        chk("ajar_close_buzz", 32'(buzz), 0);
        chk("ajar_close_servo", 32'(servo_open), 0);

        // Inactivity timeout in PIN keeps fail_cnt.
        presence = 1'b1; tick(1);
        press(4'd0); press(KEY_STAR); press(4'd5); press(KEY_HASH);
        chk("to_fail", 32'(fail_cnt), 1);
        press(4'd0); press(KEY_STAR);
        presence = 1'b0;
        tick(98);
        chk("to_c99_lcd", 32'(lcd_msg), 2);
        tick(1);
        chk("to_c100_lcd", 32'(lcd_msg), 2);
        tick(1);
        chk("to_idle_lcd", 32'(lcd_msg), 0);
        chk("to_keep_fail", 32'(fail_cnt), 1);

        // Forced entry from IDLE.
        reed_closed = 1'b0; tick(1);
        chk("forced_lcd", 32'(lcd_msg), 5);
        chk("forced_buzz", 32'(buzz), 1);
        reed_closed = 1'b1;
        tick(39);
        chk("forced_c40_buzz", 32'(buzz), 1);
        tick(1);
        chk("forced_end_buzz", 32'(buzz), 0);
        chk("forced_end_fail", 32'(fail_cnt), 0);

        // Reset mid-PIN, then forced entry overriding a correct '#'.
        presence = 1'b1; tick(1);
        press(4'd1); press(KEY_STAR); press(4'd1); press(4'd2);
        chk("mid_pid", 32'(profile_id), 1);
        reset = 1'b1; tick(1);
        chk("midrst_lcd", 32'(lcd_msg), 0);
        chk("midrst_pid", 32'(profile_id), 0);
        chk("midrst_servo", 32'(servo_open), 0);
        reset = 1'b0; tick(1);
        chk("post_rst_lcd", 32'(lcd_msg), 1);
        press(4'd1); press(KEY_STAR);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        reed_closed = 1'b0; press(KEY_HASH);
        chk("override_lcd", 32'(lcd_msg), 5);
        chk("override_servo", 32'(servo_open), 0);
        reset = 1'b1; reed_closed = 1'b1; presence = 1'b0; tick(1);
        chk("final_rst_buzz", 32'(buzz), 0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
